// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, handshakes each fetch with instruction
// memory, applies branch/jump redirects and halts on a misaligned redirect target.
module pc_sequencer #(
    parameter int            N            = 32,
    parameter logic [N-1:0]  RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         imem_ready,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic         jump,
    input  logic         jump_is_jalr,
    input  logic [N-1:0] imm,
    input  logic [N-1:0] jalr_target,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         imem_req,
    output logic         instr_valid,
    output logic         misaligned
);

    // state | meaning
    // RST   | reset applied; fetch begins on the next edge
    // FETCH | imem_req high, waiting for imem_ready
    // EXEC  | instruction at pc executing; pc updates on first non-stalled edge
    // HALT  | misaligned redirect seen; frozen until rst
    typedef enum logic [1:0] {RST, FETCH, EXEC, HALT} state_t;

    localparam logic [N-1:0] PC_STEP = N'(4);

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         misaligned_q, misaligned_d;
    logic [N-1:0] target;
    logic         redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Target priority: jump over branch over sequential; only redirects are alignment-checked.
    always_comb begin
        redirect = 1'b0;
        target   = pc_q + PC_STEP;
        if (jump) begin
            redirect = 1'b1;
            target   = jump_is_jalr ? (jalr_target & ~N'(1)) : (pc_q + imm);
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = pc_q + imm;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        case (state_q)
            RST:   state_d = FETCH;
            FETCH: if (imem_ready) state_d = EXEC;
            EXEC: begin
                if (!stall) begin
                    if (redirect && (target[1:0] != 2'b00)) begin
                        misaligned_d = 1'b1;
                        state_d      = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RST;
        endcase
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_STEP;
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table on a RESET_VECTOR=0 instance plus
// a hand-written wrap-around / JALR-misalign sequence on a RESET_VECTOR=0xFFFFFFFC instance.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, imem_ready, stall, branch_taken, jump, jump_is_jalr;
    logic [31:0] imm, jalr_target;

    logic [31:0] pc0, pc_plus4_0, pc1, pc_plus4_1;
    logic        req0, val0, mis0, req1, val1, mis1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.N(32), .RESET_VECTOR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .jump_is_jalr(jump_is_jalr),
        .imm(imm), .jalr_target(jalr_target), .pc(pc0), .pc_plus4(pc_plus4_0),
        .imem_req(req0), .instr_valid(val0), .misaligned(mis0)
    );

    pc_sequencer #(.N(32), .RESET_VECTOR(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .jump_is_jalr(jump_is_jalr),
        .imm(imm), .jalr_target(jalr_target), .pc(pc1), .pc_plus4(pc_plus4_1),
        .imem_req(req1), .instr_valid(val1), .misaligned(mis1)
    );

    typedef struct {
        logic        rst, rdy, stall, br, jmp, jalr;
        logic [31:0] imm, jt;
        logic [31:0] exp_pc;
        logic        exp_req, exp_val, exp_mis;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic st,
                                input logic b, input logic j, input logic jl,
                                input logic [31:0] im, input logic [31:0] t,
                                input logic [31:0] epc, input logic erq,
                                input logic evl, input logic ems);
        vec_t v;
        v.rst = r; v.rdy = rd; v.stall = st; v.br = b; v.jmp = j; v.jalr = jl;
        v.imm = im; v.jt = t; v.exp_pc = epc;
        v.exp_req = erq; v.exp_val = evl; v.exp_mis = ems;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic st, input logic b,
                         input logic j, input logic jl, input logic [31:0] im,
                         input logic [31:0] t);
        rst = r; imem_ready = rd; stall = st; branch_taken = b;
        jump = j; jump_is_jalr = jl; imm = im; jalr_target = t;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //              rst rdy st br jmp jl imm            jt             pc             req val mis
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0004, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0004, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 1, 0, 0));
        // imem_ready low 3 cycles, then stall 2 cycles with a redirect that must be ignored
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 1, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0008, 0, 1, 0));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 32'h100,        32'h0,         32'h0000_0008, 0, 1, 0));
        vq.push_back(mk(0, 1, 1, 1, 1, 0, 32'h100,        32'h0,         32'h0000_0008, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_000C, 1, 0, 0));
        // JAL to 0x20, then branch -0x10 twice (second wraps to 0)
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_000C, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'h14,         32'h0,         32'h0000_0020, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0020, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'hFFFF_FFF0,  32'h0,         32'h0000_0010, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0010, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'hFFFF_FFF0,  32'h0,         32'h0000_0000, 1, 0, 0));
        // JALR 0x101 together with branch: jump wins, bit 0 cleared
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 1, 1, 1, 32'h8,          32'h101,       32'h0000_0100, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0100, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 1, 0, 32'hFFFF_FF40,  32'h0,         32'h0000_0040, 1, 0, 0));
        // misaligned branch from 0x40 halts; imem_ready held high has no effect
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0040, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h2,          32'h0,         32'h0000_0040, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0040, 0, 0, 1));
        vq.push_back(mk(0, 1, 0, 1, 1, 0, 32'h4,          32'h0,         32'h0000_0040, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 0, 0));
        // rst during FETCH with imem_ready=1: back to RST, then FETCH (not EXEC)
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0004, 1, 0, 0));
        vq.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0000_0000, 1, 0, 0));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].rdy, vq[i].stall, vq[i].br, vq[i].jmp, vq[i].jalr,
                  vq[i].imm, vq[i].jt);
            @(posedge clk);
            #1;
            check($sformatf("v%0d pc", i),          pc0,                 vq[i].exp_pc);
            check($sformatf("v%0d pc_plus4", i),    pc_plus4_0,          vq[i].exp_pc + 32'd4);
            check($sformatf("v%0d imem_req", i),    {31'b0, req0},       {31'b0, vq[i].exp_req});
            check($sformatf("v%0d instr_valid", i), {31'b0, val0},       {31'b0, vq[i].exp_val});
            check($sformatf("v%0d misaligned", i),  {31'b0, mis0},       {31'b0, vq[i].exp_mis});
        end

        // Wrap-around from RESET_VECTOR=0xFFFFFFFC, then misaligned JALR after bit-0 clear
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("wrap reset pc", pc1, 32'hFFFF_FFFC);
        check("wrap reset pc_plus4", pc_plus4_1, 32'h0000_0000);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("wrap fetch req", {31'b0, req1}, 32'd1);
        @(posedge clk); #1;
        check("wrap exec valid", {31'b0, val1}, 32'd1);
        @(posedge clk); #1;
        check("wrap pc", pc1, 32'h0000_0000);
        check("wrap pc_plus4", pc_plus4_1, 32'h0000_0004);
        check("wrap misaligned", {31'b0, mis1}, 32'd0);
        check("wrap req", {31'b0, req1}, 32'd1);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 1, 1, 32'h0, 32'h103);
        @(posedge clk); #1;
        check("jalr mis misaligned", {31'b0, mis1}, 32'd1);
        check("jalr mis pc", pc1, 32'h0000_0000);
        check("jalr mis req", {31'b0, req1}, 32'd0);
        check("jalr mis valid", {31'b0, val1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
